multi_iq_cic: RTL and testbench

- Multi-channel successor to the single-channel bench-side IQ demodulator.
- Mixes N_CH ADC streams against a shared external cos/sin LO.
- Integrate-and-dump (first-order CIC) over a runtime-programmable decimation length.
- Replaces the fixed divide-by-33 with a programmable gain multiply plus saturation; emits results as a channel-serial valid/ready stream with overrun detection.
- Sits after the cavity-emulator ADC outputs (field/forward/reflect) in benches and in the feedback readback path.

---
 rtl/multi_iq_cic_pkg.sv | 21 ++
 rtl/iq_mix_acc.sv | 57 +++++
 rtl/multi_iq_cic.sv | 156 +++++++++++++++
 tb/tb_multi_iq_cic.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_iq_cic_pkg.sv
// Shared types and constants for the multi-channel IQ integrate-and-dump demodulator.
package multi_iq_cic_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StSend} ser_state_e;

    localparam int unsigned LO_SHIFT = 15;
    localparam int unsigned MIN_DEC  = 2;

    // Clamp a signed value to the range of a w-bit signed word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/iq_mix_acc.sv
// One channel of the demodulator: LO mixing, integrate-and-dump accumulation and
// snapshot capture for the I and Q paths.
module iq_mix_acc
    import multi_iq_cic_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned LO_W  = 18,
    parameter int unsigned ACC_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             dump,
    input  logic             capture,
    input  logic [IN_W-1:0]  adc,
    input  logic [LO_W-1:0]  cosd,
    input  logic [LO_W-1:0]  sind,
    output logic [ACC_W-1:0] snap_i,
    output logic [ACC_W-1:0] snap_q
);

    localparam int unsigned PROD_W = IN_W + LO_W;

    logic signed [PROD_W-1:0] prod_i, prod_q;
    logic signed [ACC_W-1:0]  term_i, term_q;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic signed [ACC_W-1:0]  acc_i_q, acc_q_q;
    logic signed [ACC_W-1:0]  snap_i_q, snap_q_q;

    assign prod_i = $signed(adc) * $signed(cosd);
    assign prod_q = $signed(adc) * $signed(sind);
    assign term_i = ACC_W'(prod_i >>> LO_SHIFT);
    assign term_q = ACC_W'(prod_q >>> LO_SHIFT);
    assign sum_i  = acc_i_q + term_i;
    assign sum_q  = acc_q_q + term_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            snap_i_q <= '0;
            snap_q_q <= '0;
        end else if (in_valid) begin
            // The dump beat's own term belongs to the closing frame.
            acc_i_q <= dump ? '0 : sum_i;
            acc_q_q <= dump ? '0 : sum_q;
            if (capture) begin
                snap_i_q <= sum_i;
                snap_q_q <= sum_q;
            end
        end
    end

    assign snap_i = snap_i_q;
    assign snap_q = snap_q_q;

endmodule

// File: rtl/multi_iq_cic.sv
// Multi-channel IQ demodulator: per-channel integrate-and-dump, programmable gain with
// saturation, and a channel-serial valid/ready output with overrun tracking.
module multi_iq_cic
    import multi_iq_cic_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned IN_W       = 16,
    parameter int unsigned LO_W       = 18,
    parameter int unsigned ACC_W      = 28,
    parameter int unsigned DEC_W      = 12,
    parameter int unsigned GAIN_W     = 18,
    parameter int unsigned GAIN_SHIFT = 22,
    parameter int unsigned OUT_W      = 18,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [N_CH*IN_W-1:0] adc,
    input  logic [LO_W-1:0]      cosd,
    input  logic [LO_W-1:0]      sind,
    input  logic [DEC_W-1:0]     dec_len,
    input  logic [GAIN_W-1:0]    gain,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [OUT_W-1:0]     out_i,
    output logic [OUT_W-1:0]     out_q,
    output logic                 out_last,
    output logic                 overrun,
    output logic [7:0]           overrun_cnt
);

    localparam int unsigned SCL_W = ACC_W + GAIN_W + 1;

    ser_state_e              state_q;
    logic [DEC_W-1:0]        bc_q, d_q;
    logic                    dump, capture;
    logic [ACC_W-1:0]        snap_i [N_CH];
    logic [ACC_W-1:0]        snap_q [N_CH];
    logic [CH_W-1:0]         sel_ch;
    logic signed [ACC_W-1:0] sel_i, sel_q;
    logic signed [SCL_W-1:0] scl_i, scl_q;
    logic [OUT_W-1:0]        scaled_i, scaled_q;

    // d_q is only meaningful once bc_q has left 0, so the dump test is gated on that.
    assign dump    = in_valid && (bc_q != '0) && (bc_q == d_q - 1'b1);
    assign capture = dump && (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_q <= '0;
            d_q  <= '0;
        end else if (in_valid) begin
            if (bc_q == '0) begin
                d_q  <= (dec_len < DEC_W'(MIN_DEC)) ? DEC_W'(MIN_DEC) : dec_len;
                bc_q <= DEC_W'(1);
            end else if (dump) begin
                bc_q <= '0;
            end else begin
                bc_q <= bc_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        iq_mix_acc #(
            .IN_W  (IN_W),
            .LO_W  (LO_W),
            .ACC_W (ACC_W)
        ) u_mix (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .dump     (dump),
            .capture  (capture),
            .adc      (adc[k*IN_W +: IN_W]),
            .cosd     (cosd),
            .sind     (sind),
            .snap_i   (snap_i[k]),
            .snap_q   (snap_q[k])
        );
    end

    // The scaler always looks at the word that will be presented after the next transfer.
    assign sel_ch = (state_q == StSend) ? out_ch + 1'b1 : '0;

    always_comb begin
        sel_i = '0;
        sel_q = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_ch == CH_W'(k)) begin
                sel_i = snap_i[k];
                sel_q = snap_q[k];
            end
        end
    end

    assign scl_i    = sel_i * $signed({1'b0, gain});
    assign scl_q    = sel_q * $signed({1'b0, gain});
    assign scaled_i = OUT_W'(sat_signed(64'(scl_i >>> GAIN_SHIFT), OUT_W));
    assign scaled_q = OUT_W'(sat_signed(64'(scl_q >>> GAIN_SHIFT), OUT_W));

    assign out_last = out_valid && (out_ch == CH_W'(N_CH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (capture) state_q <= StLoad;
                end
                StLoad: begin
                    state_q   <= StSend;
                    out_valid <= 1'b1;
                    out_ch    <= '0;
                    out_i     <= scaled_i;
                    out_q     <= scaled_q;
                end
                StSend: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                        end else begin
                            out_ch <= out_ch + 1'b1;
                            out_i  <= scaled_i;
                            out_q  <= scaled_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (clear) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (dump && (state_q != StIdle)) begin
            overrun <= 1'b1;
            if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_iq_cic.sv
// Randomised scoreboard bench for multi_iq_cic against a frame-level reference model.
module tb_multi_iq_cic;

    localparam int N_CH       = 3;
    localparam int IN_W       = 16;
    localparam int LO_W       = 18;
    localparam int ACC_W      = 28;
    localparam int DEC_W      = 12;
    localparam int GAIN_W     = 23;  // unity gain (2^22) needs 23 bits
    localparam int GAIN_SHIFT = 22;
    localparam int OUT_W      = 18;
    localparam int CH_W       = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [N_CH*IN_W-1:0] adc = '0;
    logic [LO_W-1:0]      cosd = '0;
    logic [LO_W-1:0]      sind = '0;
    logic [DEC_W-1:0]     dec_len = '0;
    logic [GAIN_W-1:0]    gain = '0;
    logic                 clear = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic [CH_W-1:0]      out_ch;
    logic [OUT_W-1:0]     out_i;
    logic [OUT_W-1:0]     out_q;
    logic                 out_last;
    logic                 overrun;
    logic [7:0]           overrun_cnt;

    multi_iq_cic #(
        .N_CH(N_CH), .IN_W(IN_W), .LO_W(LO_W), .ACC_W(ACC_W), .DEC_W(DEC_W),
        .GAIN_W(GAIN_W), .GAIN_SHIFT(GAIN_SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .adc(adc), .cosd(cosd), .sind(sind),
        .dec_len(dec_len), .gain(gain), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out_i(out_i), .out_q(out_q),
        .out_last(out_last), .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint i;
        longint q;
        bit     last;
    } word_t;

    word_t  exp_q[$];
    int     errors = 0;
    int     checks = 0;

    int     adc_v[N_CH];
    int     cos_v, sin_v;
    longint sum_i[N_CH], sum_q[N_CH];
    int     m_bc, m_d, m_ch, m_cnt;
    bit     m_busy, m_load, m_ovr;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    function automatic longint scale(input longint s, input longint g);
        longint y, hi, lo;
        y  = (s * g) >>> GAIN_SHIFT;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        if (y > hi) return hi;
        if (y < lo) return lo;
        return y;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            sum_i[k] = 0;
            sum_q[k] = 0;
        end
        m_bc = 0; m_d = 0; m_ch = 0; m_cnt = 0;
        m_busy = 0; m_load = 0; m_ovr = 0;
        exp_q.delete();
    endtask

    // One clock of the reference: frames of D beats, one frame in flight at a time.
    task automatic model_cycle();
        bit     dmp, was_busy, hs, ovr_evt;
        longint si[N_CH], sq[N_CH];
        dmp = 0;
        ovr_evt = 0;
        was_busy = m_busy;
        hs = m_busy && !m_load && out_ready;
        if (in_valid) begin
            if (m_bc == 0) m_d = (dec_len < 2) ? 2 : int'(dec_len);
            for (int k = 0; k < N_CH; k++) begin
                sum_i[k] = wrap_acc(sum_i[k] + ((longint'(adc_v[k]) * longint'(cos_v)) >>> 15));
                sum_q[k] = wrap_acc(sum_q[k] + ((longint'(adc_v[k]) * longint'(sin_v)) >>> 15));
            end
            if (m_bc == m_d - 1) begin
                dmp = 1;
                for (int k = 0; k < N_CH; k++) begin
                    si[k] = sum_i[k];
                    sq[k] = sum_q[k];
                    sum_i[k] = 0;
                    sum_q[k] = 0;
                end
                m_bc = 0;
            end else begin
                m_bc++;
            end
        end
        if (m_load) begin
            m_load = 0;
        end else if (hs) begin
            m_ch++;
            if (m_ch == N_CH) begin
                m_busy = 0;
                m_ch = 0;
            end
        end
        if (dmp && !was_busy) begin
            m_busy = 1;
            m_load = 1;
            m_ch = 0;
            for (int k = 0; k < N_CH; k++)
                exp_q.push_back('{ch: k, i: scale(si[k], longint'(gain)),
                                  q: scale(sq[k], longint'(gain)), last: (k == N_CH - 1)});
        end else if (dmp) begin
            ovr_evt = 1;
        end
        if (clear) begin
            m_ovr = 0;
            m_cnt = 0;
        end else if (ovr_evt) begin
            m_ovr = 1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic step();
        bit ev;
        if (rst_n) model_cycle();
        @(posedge clk);
        #1;
        if (rst_n) begin
            ev = m_busy && !m_load;
            check("out_valid", out_valid, ev);
            if (ev) check("out_ch", out_ch, m_ch);
            check("out_last", out_last, ev && (m_ch == N_CH - 1));
            check("overrun", overrun, m_ovr);
            check("overrun_cnt", overrun_cnt, m_cnt);
        end else begin
            check("out_valid_in_reset", out_valid, 0);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N_CH; k++) adc[k*IN_W +: IN_W] = adc_v[k][IN_W-1:0];
        cosd = cos_v[LO_W-1:0];
        sind = sin_v[LO_W-1:0];
    endtask

    task automatic rand_sample();
        for (int k = 0; k < N_CH; k++) adc_v[k] = int'($urandom_range(0, 65535)) - 32768;
        cos_v = int'($urandom_range(0, 262143)) - 131072;
        sin_v = int'($urandom_range(0, 262143)) - 131072;
        drive();
    endtask

    task automatic set_all(input int a, input int c, input int s);
        for (int k = 0; k < N_CH; k++) adc_v[k] = a;
        cos_v = c;
        sin_v = s;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            step();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: out_valid=0 after %0d cycles, expected 1", name, limit);
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((m_busy || exp_q.size() > 0) && n < 100) begin
            step();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin : mon
            word_t w;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected word ch=%0d i=%0d, expected none",
                         out_ch, $signed(out_i));
            end else begin
                w = exp_q.pop_front();
                check("word_ch", out_ch, w.ch);
                check("word_i", $signed(out_i), w.i);
                check("word_q", $signed(out_q), w.q);
                check("word_last", out_last, w.last);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bit bp_done;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_i", out_i, 0);
        check("rst_out_q", out_q, 0);
        check("rst_overrun", overrun, 0);
        check("rst_overrun_cnt", overrun_cnt, 0);
        rst_n = 1'b1;

        // DC frame with unity gain.
        gain = GAIN_W'(1 << 22);
        dec_len = DEC_W'(8);
        out_ready = 1'b1;
        adc_v[0] = 1000; adc_v[1] = -2000; adc_v[2] = 4000;
        cos_v = 32768; sin_v = 0;
        drive();
        in_valid = 1'b1;
        wait_valid(20, "dc_first_valid");
        check("dc_ch0_i", $signed(out_i), 8000);
        check("dc_ch0_q", $signed(out_q), 0);
        step();
        check("dc_ch1_i", $signed(out_i), -16000);
        check("dc_ch1", out_ch, 1);
        step();
        check("dc_ch2_i", $signed(out_i), 32000);
        check("dc_ch2_last", out_last, 1);
        repeat (30) step();

        // Back-pressure on channel 1.
        dec_len = DEC_W'(16);
        bp_done = 0;
        for (int n = 0; n < 80; n++) begin
            if (!bp_done && out_valid && out_ch == 1) begin
                out_ready = 1'b0;
                repeat (5) begin
                    step();
                    check("bp_hold_ch", out_ch, 1);
                    check("bp_hold_i", $signed(out_i), exp_q[0].i);
                end
                out_ready = 1'b1;
                bp_done = 1;
            end
            step();
        end
        check("bp_exercised", bp_done, 1);
        drain();

        // Overrun saturation and clear.
        dec_len = DEC_W'(2);
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (600) step();
        check("ovr_flag", overrun, 1);
        check("ovr_cnt_sat", overrun_cnt, 255);
        clear = 1'b1;
        repeat (2) step();
        clear = 1'b0;
        check("ovr_clear_cnt", overrun_cnt, 0);
        check("ovr_clear_flag", overrun, 0);
        repeat (5) step();
        drain();

        // Saturation, positive then mirrored.
        do_reset();
        dec_len = DEC_W'(64);
        out_ready = 1'b1;
        set_all(32767, 131071, -131072);
        in_valid = 1'b1;
        wait_valid(80, "sat_pos_valid");
        check("sat_pos_i", $signed(out_i), 131071);
        check("sat_pos_q", $signed(out_q), -131072);
        do_reset();
        set_all(-32768, 131071, -131072);
        wait_valid(80, "sat_neg_valid");
        check("sat_neg_i", $signed(out_i), -131072);
        check("sat_neg_q", $signed(out_q), 131071);
        drain();

        // dec_len=1 behaves as 2; mid-frame length change applies to the next frame.
        do_reset();
        dec_len = DEC_W'(1);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin rand_sample(); step(); end
        do_reset();
        dec_len = DEC_W'(8);
        for (int n = 0; n < 3; n++) begin rand_sample(); step(); end
        dec_len = DEC_W'(4);
        for (int n = 0; n < 30; n++) begin rand_sample(); step(); end
        drain();

        // Reset during SEND, then a post-reset-only frame.
        dec_len = DEC_W'(8);
        out_ready = 1'b0;
        set_all(1000, 32768, 0);
        in_valid = 1'b1;
        wait_valid(40, "rst_send_valid");
        do_reset();
        out_ready = 1'b1;
        wait_valid(20, "post_rst_valid");
        check("post_rst_i", $signed(out_i), 8000);
        drain();

        // Randomised traffic.
        gain = GAIN_W'($urandom_range(0, (1 << GAIN_W) - 1));
        for (int n = 0; n < 1500; n++) begin
            rand_sample();
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) == 0) dec_len = DEC_W'($urandom_range(0, 12));
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
